// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: controller state encoding and
// the quotient bit pattern reported on a divide by zero.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Replicated across the full quotient width to give all ones.
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    logic [N:0]   shifted;
    logic [N+1:0] diff;
    logic         unused_step;

    assign shifted = {rem_i, bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

    // No borrow means the divisor fit; both outcomes are below the divisor,
    // so the top bit of either candidate is always zero.
    assign qbit_o      = ~diff[N+1];
    assign rem_o       = qbit_o ? diff[N-1:0] : shifted[N-1:0];
    assign unused_step = diff[N] ^ shifted[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle. Two's-complement
// operation is available when the SEQ_DIVIDER_SIGNED_EN macro is defined.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero
);

    localparam int            CW        = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          div_zero_q, div_zero_d;
    logic          done_q, done_d;

    logic          a_neg, b_neg;
    logic [N-1:0]  a_mag, b_mag;
    logic [N-1:0]  step_rem;
    logic          step_qbit;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign a_neg = is_signed & A[N-1];
    assign b_neg = is_signed & B[N-1];
`else
    logic unused_signed;
    assign unused_signed = is_signed;
    assign a_neg         = 1'b0;
    assign b_neg         = 1'b0;
`endif

    // The magnitude of the most-negative value still fits as an unsigned N-bit number.
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[N-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        dz_d       = dz_q;
        q_d        = q_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    rem_d  = '0;
                    if (B == '0) begin
                        dvd_d   = A;
                        dvs_d   = '0;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d      = a_mag;
                        dvs_d      = b_mag;
                        negq_d     = a_neg ^ b_neg;
                        negr_d     = a_neg;
                        dz_d       = 1'b0;
                        div_zero_d = 1'b0;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                // The dividend register doubles as the quotient shift register.
                dvd_d = {dvd_q[N-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    q_d        = {N{DIV_ZERO_Q_BIT}};
                    r_d        = dvd_q;
                    div_zero_d = 1'b1;
                end else begin
                    q_d = negq_q ? -dvd_q : dvd_q;
                    r_d = negr_q ? -rem_q : rem_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dz_q       <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            dz_q       <= dz_d;
            q_q        <= q_d;
            r_q        <= r_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    // Results are published on the edge leaving DONE, so the done cycle itself
    // sits in IDLE and must still report busy.
    assign busy     = (state_q != IDLE) | done_q;
    assign done     = done_q;
    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus hand-written corner
// sequences, with a done-driven scoreboard checking results and latency.
module tb_seq_divider;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          busy;
    logic          done;
    logic [N-1:0]  Q;
    logic [N-1:0]  R;
    logic          div_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          c0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   errors;
    int   done_cnt;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Q         (Q),
        .R         (R),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done with nothing outstanding at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("Q", Q, mon_e.q);
                chk("R", R, mon_e.r);
                chk("div_zero", {31'b0, div_zero}, {31'b0, mon_e.dz});
                chk("latency", 32'(cyc - mon_e.c0), 32'(mon_e.lat));
                chk("busy_on_done", {31'b0, busy}, 32'd1);
            end
        end
    end

    task automatic launch(input vec_t v);
        exp_t e;
        @(negedge clk);
        A         = v.a;
        B         = v.b;
        is_signed = v.s;
        start     = 1'b1;
        e.q  = v.q;
        e.r  = v.r;
        e.dz = v.dz;
        e.c0 = cyc + 1;
        e.lat = v.lat;
        sb.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        A         = $urandom;
        B         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        chk("outstanding_after_wait", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   c0;
        int   dc0;
        vec_t v;
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        A         = '0;
        B         = '0;

        tbl.push_back('{a:32'd100,        b:32'd7,          s:1'b0, q:32'd14,         r:32'd2,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'h12345678,   b:32'd0,          s:1'b0, q:32'hFFFFFFFF,   r:32'h12345678,   dz:1'b1, lat:1});
        tbl.push_back('{a:32'd100,        b:32'd7,          s:1'b0, q:32'd14,         r:32'd2,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'd9,          b:32'd4,          s:1'b0, q:32'd2,          r:32'd1,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'd0,          b:32'd5,          s:1'b0, q:32'd0,          r:32'd0,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'd7,          b:32'd9,          s:1'b0, q:32'd0,          r:32'd7,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'hFFFFFFFF,   b:32'hFFFFFFFF,   s:1'b0, q:32'd1,          r:32'd0,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'h80000000,   b:32'd2,          s:1'b0, q:32'h40000000,   r:32'd0,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'hFFFFFFFF,   b:32'd0,          s:1'b1, q:32'hFFFFFFFF,   r:32'hFFFFFFFF,   dz:1'b1, lat:1});
`ifdef SEQ_DIVIDER_SIGNED_EN
        tbl.push_back('{a:32'hFFFFFF9C,   b:32'd7,          s:1'b1, q:32'hFFFFFFF2,   r:32'hFFFFFFFE,   dz:1'b0, lat:33});
        tbl.push_back('{a:32'h80000000,   b:32'hFFFFFFFF,   s:1'b1, q:32'h80000000,   r:32'd0,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'd100,        b:32'hFFFFFFF9,   s:1'b1, q:32'hFFFFFFF2,   r:32'd2,          dz:1'b0, lat:33});
`else
        tbl.push_back('{a:32'hFFFFFF9C,   b:32'd7,          s:1'b1, q:32'h24924916,   r:32'd2,          dz:1'b0, lat:33});
        tbl.push_back('{a:32'h80000000,   b:32'hFFFFFFFF,   s:1'b1, q:32'd0,          r:32'h80000000,   dz:1'b0, lat:33});
        tbl.push_back('{a:32'd100,        b:32'hFFFFFFF9,   s:1'b1, q:32'd0,          r:32'd100,        dz:1'b0, lat:33});
`endif
        tbl.push_back('{a:32'hFFFFFF9C,   b:32'd7,          s:1'b0, q:32'h24924916,   r:32'd2,          dz:1'b0, lat:33});

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_Q", Q, 32'd0);
        chk("reset_R", R, 32'd0);
        chk("reset_div_zero", {31'b0, div_zero}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            launch(tbl[i]);
            drain();
        end

        // Extra start pulsed mid-run must be neither executed nor queued.
        dc0 = done_cnt;
        v = '{a:32'hFFFFFFFF, b:32'd1, s:1'b0, q:32'hFFFFFFFF, r:32'd0, dz:1'b0, lat:33};
        launch(v);
        repeat (8) @(negedge clk);
        A     = 32'd5;
        B     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("single_done_count", 32'(done_cnt - dc0), 32'd1);

        // Asynchronous reset in the middle of a run.
        v = '{a:32'd100, b:32'd7, s:1'b0, q:32'd14, r:32'd2, dz:1'b0, lat:33};
        launch(v);
        repeat (13) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
        chk("midrun_rst_done", {31'b0, done}, 32'd0);
        chk("midrun_rst_Q", Q, 32'd0);
        chk("midrun_rst_R", R, 32'd0);
        chk("midrun_rst_div_zero", {31'b0, div_zero}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        v = '{a:32'd9, b:32'd4, s:1'b0, q:32'd2, r:32'd1, dz:1'b0, lat:33};
        launch(v);
        drain();

        // Start held high: back-to-back operations every N+2 cycles.
        @(negedge clk);
        A         = 32'd1000;
        B         = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        c0        = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{q:32'd142, r:32'd6, dz:1'b0, c0:c0 + k * (N + 2), lat:33});
        end
        repeat (2 * (N + 2) + 1) @(negedge clk);
        start = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits (N >= 4).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  selects two's-complement operation; sampled with start.
REQ-006 SHALL have port A  input  N  dividend; sampled with start.
REQ-007 SHALL have port B  input  N  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when Q/R become valid.
REQ-010 SHALL have port Q  output  N  quotient, held until the next accepted start.
REQ-011 SHALL have port R  output  N  remainder, held until the next accepted start.
REQ-012 SHALL have port div_zero  output  1  set with done when B was zero; held with Q/R.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after N iterations, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL accept start only in IDLE; start in RUN or DONE is ignored, with no latching and no queuing.
REQ-015 SHALL latch operands on the accepting edge, so later changes to A/B/is_signed have no effect on the operation.
REQ-016 SHALL perform one restoring step per RUN cycle: shift {rem, dividend MSB} left, subtract divisor (N+1-bit), keep difference and shift in quotient bit 1 if no borrow, else restore and shift in 0.
REQ-017 SHALL assert done exactly N+1 cycles after the accepting edge (N=32: cycle 33), with Q/R/div_zero valid in that same cycle.
REQ-018 SHALL assert busy from the cycle after the accepting edge through the done cycle inclusive.
REQ-019 SHALL, for B==0, skip RUN (IDLE->DONE), pulse done on the next cycle with Q = all ones, R = A, div_zero = 1.
REQ-020 SHALL clear div_zero on every accepted start with B != 0.
REQ-021 SHALL permit a new start in the cycle immediately after done (back-to-back operation).

Reset
REQ-022 SHALL, on rst_n low at any time including mid-RUN, force IDLE and clear busy, done, Q, R, div_zero and all internal registers to 0 without waiting for clk.
REQ-023 SHALL ignore start in the first rising edge of clk after rst_n deasserts only if rst_n is still low at that edge; otherwise it is accepted normally.

Configuration
REQ-024 SHALL gate signed support with the macro SEQ_DIVIDER_SIGNED_EN.
REQ-025 SHALL, when SEQ_DIVIDER_SIGNED_EN is defined and is_signed=1, divide magnitudes, negate Q if operand signs differ, and give R the sign of A (truncating division); latency is unchanged.
REQ-026 SHALL, when SEQ_DIVIDER_SIGNED_EN is defined, produce Q = most-negative and R = 0 for most-negative / -1.
REQ-027 SHALL, without SEQ_DIVIDER_SIGNED_EN, ignore is_signed and always perform unsigned division, keeping the port present.

Structure
REQ-028 SHALL take the state enum (IDLE, RUN, DONE) and the divide-by-zero quotient constant from shared package div_pkg.
REQ-029 SHALL place the single-iteration subtract/restore datapath in sub-module div_step (inputs rem, divisor; outputs next rem, quotient bit).
REQ-030 SHALL size the iteration counter to $clog2(N+1) bits.

Verification
REQ-031 SHALL verify: N=32, A=100, B=7, unsigned -> done at cycle 33, Q=14, R=2, div_zero=0.
REQ-032 SHALL verify: A=0x12345678, B=0 -> done at cycle 1, Q=0xFFFFFFFF, R=0x12345678, div_zero=1.
REQ-033 SHALL verify: signed build, is_signed=1, A=-100 (0xFFFFFF9C), B=7 -> Q=0xFFFFFFF2, R=0xFFFFFFFE.
REQ-034 SHALL verify: A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0; an extra start pulsed at cycle 10 is ignored, with exactly one done.
REQ-035 SHALL verify: rst_n pulsed low at cycle 15 of a run -> busy=0, Q=R=0 immediately; a fresh start of 9/4 afterwards -> Q=2, R=1.
REQ-036 SHALL verify: start held high continuously -> operations repeat every N+2 cycles, each done accompanied by correct results.
